// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator ALU. Each instruction takes
// three cycles, jumps can depend on the ALU carry, and HLT parks it until reset.

package instr_sequencer_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LD  = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_XOR = 4'h6,
        OP_NOT = 4'h7,
        OP_JMP = 4'h8,
        OP_JC  = 4'h9,
        OP_JNC = 4'hA,
        OP_HLT = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALT
    } state_e;

endpackage

module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_WIDTH       = 8,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int OPCODE_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    output logic [PC_WIDTH-1:0]       rom_addr,
    input  logic [11:0]               rom_data,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr,
    input  logic                      cy,
    output logic [OPCODE_WIDTH-1:0]   opcode,
    output logic                      alu_ce,
    output logic                      cy_ce,
    output logic                      halted
);

    state_e                  state;
    logic [PC_WIDTH-1:0]     pc;
    logic [11:0]             ir;

    logic [3:0]              rom_op;
    logic [3:0]              ir_op;
    logic [PC_WIDTH-1:0]     target;

    logic [OPCODE_WIDTH-1:0] dec_opcode;
    logic                    dec_alu_ce;
    logic                    dec_cy_ce;
    logic [PC_WIDTH-1:0]     pc_next;
    logic                    take_halt;

    assign rom_addr = pc;
    assign reg_addr = ir[REG_ADDR_WIDTH-1:0];
    assign rom_op   = rom_data[11:8];
    assign ir_op    = ir[11:8];
    assign target   = PC_WIDTH'(ir[7:0]);

    // Decode straight from the ROM word in DECODE so the ALU controls can be
    // registered on the same edge that loads IR and land exactly in EXECUTE.
    // NOTE: every output gets a default before the case, so no latch is inferred.
    always_comb begin
        dec_opcode = OPCODE_WIDTH'(OP_NOP);
        dec_alu_ce = 1'b0;
        dec_cy_ce  = 1'b0;
        case (rom_op)
            OP_LD, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                dec_opcode = OPCODE_WIDTH'(rom_op);
                dec_alu_ce = 1'b1;
            end
            OP_ADD, OP_SUB: begin
                dec_opcode = OPCODE_WIDTH'(rom_op);
                dec_alu_ce = 1'b1;
                dec_cy_ce  = 1'b1;
            end
            default: ;
        endcase
    end

    // Next PC for the instruction in IR; only consumed in EXECUTE, where cy
    // already holds the carry of the previous ALU instruction.
    always_comb begin
        pc_next   = pc + PC_WIDTH'(1);
        take_halt = 1'b0;
        case (ir_op)
            OP_JMP: pc_next = target;
            OP_JC:  if (cy)  pc_next = target;
            OP_JNC: if (!cy) pc_next = target;
            OP_HLT: begin
                pc_next   = pc;
                take_halt = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_FETCH;
            pc     <= '0;
            ir     <= '0;
            opcode <= '0;
            alu_ce <= 1'b0;
            cy_ce  <= 1'b0;
            halted <= 1'b0;
        end else begin
            // ALU controls are one-cycle pulses; anything but EXECUTE sees NOP.
            opcode <= OPCODE_WIDTH'(OP_NOP);
            alu_ce <= 1'b0;
            cy_ce  <= 1'b0;
            case (state)
                ST_FETCH: begin
                    if (en) state <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir     <= rom_data;
                    opcode <= dec_opcode;
                    alu_ce <= dec_alu_ce;
                    cy_ce  <= dec_cy_ce;
                    state  <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    pc <= pc_next;
                    if (take_halt) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        state  <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ROM, register file and ALU around the DUT, with an
// instruction-level model feeding a queue of expected per-instruction behaviour.

module tb_instr_sequencer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data;
    logic [2:0]  reg_addr;
    logic        cy;
    logic [3:0]  opcode;
    logic        alu_ce;
    logic        cy_ce;
    logic        halted;

    logic [11:0] rom [256];
    logic [7:0]  regs [8];
    logic [7:0]  reg_val;
    logic [7:0]  acc;
    logic        alu_clr;
    logic [8:0]  alu_res;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_acc;
    logic       m_cy;

    typedef struct {
        logic [7:0] pc;
        logic [3:0] op;
        logic       alu_ce;
        logic       cy_ce;
        logic [2:0] ra;
        logic [7:0] next_pc;
        logic       halt;
    } exp_t;

    exp_t exp_q[$];

    instr_sequencer #(
        .PC_WIDTH       (8),
        .REG_ADDR_WIDTH (3),
        .OPCODE_WIDTH   (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .reg_addr (reg_addr),
        .cy       (cy),
        .opcode   (opcode),
        .alu_ce   (alu_ce),
        .cy_ce    (cy_ce),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accumulator ALU behaviour: returns {carry, acc}.
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic c);
        case (op)
            4'h1:    return {c, b};
            4'h2:    return {1'b0, a} + {1'b0, b};
            4'h3:    return {1'b0, a} - {1'b0, b};
            4'h4:    return {c, a & b};
            4'h5:    return {c, a | b};
            4'h6:    return {c, a ^ b};
            4'h7:    return {c, ~a};
            default: return {c, a};
        endcase
    endfunction

    always @(posedge clk) rom_data <= rom[rom_addr];
    assign reg_val = regs[reg_addr];
    assign alu_res = alu_fn(opcode, acc, reg_val, cy);

    always @(posedge clk) begin
        if (alu_clr) begin
            acc <= 8'h00;
            cy  <= 1'b0;
        end else begin
            if (alu_ce) acc <= alu_res[7:0];
            if (cy_ce)  cy  <= alu_res[8];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom;
        for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    endtask

    // Leaves the DUT in its first FETCH cycle with en=0.
    task automatic do_reset;
        rst_n   = 1'b0;
        en      = 1'b0;
        alu_clr = 1'b1;
        tick;
        tick;
        rst_n   = 1'b1;
        alu_clr = 1'b0;
        m_acc   = 8'h00;
        m_cy    = 1'b0;
    endtask

    // Instruction-level interpreter: walks the program from address 0 and
    // queues what each instruction must look like on the DUT pins.
    task automatic predict(input int max_steps);
        logic [7:0]  pc;
        logic [7:0]  nxt;
        logic [11:0] w;
        logic [3:0]  op;
        logic [8:0]  res;
        exp_t        e;
        pc = 8'h00;
        for (int s = 0; s < max_steps; s++) begin
            w        = rom[pc];
            op       = w[11:8];
            e.pc     = pc;
            e.ra     = w[2:0];
            e.halt   = (op == 4'hF);
            e.alu_ce = (op >= 4'h1) && (op <= 4'h7);
            e.cy_ce  = (op == 4'h2) || (op == 4'h3);
            e.op     = e.alu_ce ? op : 4'h0;
            if (e.alu_ce) begin
                res   = alu_fn(op, m_acc, regs[w[2:0]], m_cy);
                m_acc = res[7:0];
                if (e.cy_ce) m_cy = res[8];
            end
            case (op)
                4'h8:    nxt = w[7:0];
                4'h9:    nxt = m_cy ? w[7:0] : pc + 8'd1;
                4'hA:    nxt = !m_cy ? w[7:0] : pc + 8'd1;
                4'hF:    nxt = pc;
                default: nxt = pc + 8'd1;
            endcase
            e.next_pc = nxt;
            exp_q.push_back(e);
            if (e.halt) break;
            pc = nxt;
        end
    endtask

    // Scoreboard consumer: starts in a FETCH cycle, en must be 1.
    task automatic drain(input string tag);
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rom_addr !== e.pc) begin
                n_err++;
                $display("FAIL %s fetch rom_addr: got %h expected %h", tag, rom_addr, e.pc);
            end
            n_vec++;
            if ({opcode, alu_ce, cy_ce} !== 6'b0) begin
                n_err++;
                $display("FAIL %s fetch ctrl pc=%h: got %b expected 000000", tag, e.pc, {opcode, alu_ce, cy_ce});
            end
            n_vec++;
            if (halted !== 1'b0) begin
                n_err++;
                $display("FAIL %s fetch halted pc=%h: got %b expected 0", tag, e.pc, halted);
            end
            tick;
            n_vec++;
            if ({opcode, alu_ce, cy_ce} !== 6'b0) begin
                n_err++;
                $display("FAIL %s decode ctrl pc=%h: got %b expected 000000", tag, e.pc, {opcode, alu_ce, cy_ce});
            end
            tick;
            n_vec++;
            if ({opcode, alu_ce, cy_ce} !== {e.op, e.alu_ce, e.cy_ce}) begin
                n_err++;
                $display("FAIL %s execute ctrl pc=%h: got %b expected %b", tag, e.pc,
                         {opcode, alu_ce, cy_ce}, {e.op, e.alu_ce, e.cy_ce});
            end
            n_vec++;
            if (reg_addr !== e.ra) begin
                n_err++;
                $display("FAIL %s execute reg_addr pc=%h: got %h expected %h", tag, e.pc, reg_addr, e.ra);
            end
            tick;
            n_vec++;
            if (rom_addr !== e.next_pc) begin
                n_err++;
                $display("FAIL %s next rom_addr pc=%h: got %h expected %h", tag, e.pc, rom_addr, e.next_pc);
            end
            n_vec++;
            if (halted !== e.halt) begin
                n_err++;
                $display("FAIL %s halted after pc=%h: got %b expected %b", tag, e.pc, halted, e.halt);
            end
        end
    endtask

    task automatic test_reset;
        do_reset;
        n_vec++;
        if ({rom_addr, reg_addr, opcode, alu_ce, cy_ce, halted} !== 18'h0) begin
            n_err++;
            $display("FAIL reset values: got %h expected 0", {rom_addr, reg_addr, opcode, alu_ce, cy_ce, halted});
        end
    endtask

    task automatic test_basic;
        clear_rom;
        rom[0] = 12'h100;
        rom[1] = 12'h201;
        rom[2] = 12'hF00;
        regs[0] = 8'h05;
        regs[1] = 8'h03;
        do_reset;
        en = 1'b1;
        predict(16);
        drain("basic");
        n_vec++;
        if (acc !== 8'h08) begin
            n_err++;
            $display("FAIL basic acc: got %h expected 08", acc);
        end
        for (int i = 0; i < 4; i++) begin
            tick;
            n_vec++;
            if ({rom_addr, opcode, halted} !== {8'h02, 4'h0, 1'b1}) begin
                n_err++;
                $display("FAIL basic halt hold: got %h/%h/%b expected 02/0/1", rom_addr, opcode, halted);
            end
        end
    endtask

    task automatic run_jump(input string tag, input logic [7:0] r0, input logic [7:0] r1,
                            input logic [11:0] jump_word, input logic [7:0] final_pc);
        clear_rom;
        rom[0] = 12'h100;
        rom[1] = 12'h201;
        rom[2] = jump_word;
        rom[3] = 12'hF00;
        rom[jump_word[7:0]] = 12'hF00;
        regs[0] = r0;
        regs[1] = r1;
        do_reset;
        en = 1'b1;
        predict(16);
        drain(tag);
        n_vec++;
        if ({rom_addr, halted} !== {final_pc, 1'b1}) begin
            n_err++;
            $display("FAIL %s final: got %h/%b expected %h/1", tag, rom_addr, halted, final_pc);
        end
    endtask

    task automatic test_cond_jumps;
        run_jump("jc_taken",     8'hFF, 8'h01, 12'h910, 8'h10);
        run_jump("jc_not_taken", 8'hFF, 8'h00, 12'h910, 8'h03);
        run_jump("jnc_taken",    8'h01, 8'h01, 12'hA20, 8'h20);
        run_jump("jnc_not",      8'hFF, 8'h01, 12'hA20, 8'h03);
    endtask

    task automatic test_wrap;
        clear_rom;
        do_reset;
        en = 1'b1;
        predict(256);
        drain("nop_wrap");
        n_vec++;
        if (rom_addr !== 8'h00) begin
            n_err++;
            $display("FAIL nop_wrap rom_addr: got %h expected 00", rom_addr);
        end
        clear_rom;
        rom[8'hFF] = 12'h800;
        rom[0]     = 12'h100;
        regs[0]    = 8'h5A;
        do_reset;
        en = 1'b1;
        predict(257);
        drain("jmp_loop");
        n_vec++;
        if ({rom_addr, acc} !== {8'h01, 8'h5A}) begin
            n_err++;
            $display("FAIL jmp_loop end: got %h expected 015a", {rom_addr, acc});
        end
    endtask

    task automatic stall_check(input string tag, input logic [7:0] pc);
        for (int i = 0; i < 10; i++) begin
            tick;
            n_vec++;
            if ({rom_addr, opcode, alu_ce, cy_ce} !== {pc, 6'b0}) begin
                n_err++;
                $display("FAIL %s cycle %0d: got %h expected %h", tag, i, {rom_addr, opcode, alu_ce, cy_ce}, {pc, 6'b0});
            end
        end
    endtask

    task automatic test_stall;
        clear_rom;
        rom[0] = 12'h100;
        rom[1] = 12'h201;
        rom[2] = 12'hF00;
        regs[0] = 8'h05;
        regs[1] = 8'h03;
        do_reset;
        stall_check("stall_pc0", 8'h00);
        en = 1'b1;
        tick;
        en = 1'b0;
        tick;
        n_vec++;
        if ({opcode, alu_ce, cy_ce} !== 6'b0001_10) begin
            n_err++;
            $display("FAIL stall ld execute: got %b expected 000110", {opcode, alu_ce, cy_ce});
        end
        tick;
        stall_check("stall_pc1", 8'h01);
        en = 1'b1;
        tick;
        en = 1'b0;
        tick;
        n_vec++;
        if ({opcode, alu_ce, cy_ce} !== 6'b0010_11) begin
            n_err++;
            $display("FAIL stall add execute: got %b expected 001011", {opcode, alu_ce, cy_ce});
        end
        tick;
        n_vec++;
        if ({rom_addr, acc} !== {8'h02, 8'h08}) begin
            n_err++;
            $display("FAIL stall end: got %h expected 0208", {rom_addr, acc});
        end
    endtask

    task automatic test_reset_mid;
        clear_rom;
        rom[0] = 12'h100;
        rom[1] = 12'h201;
        rom[2] = 12'hF00;
        regs[0] = 8'h05;
        regs[1] = 8'h03;
        do_reset;
        en = 1'b1;
        repeat (5) tick;
        n_vec++;
        if (opcode !== 4'h2) begin
            n_err++;
            $display("FAIL mid add execute opcode: got %h expected 2", opcode);
        end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        n_vec++;
        if ({rom_addr, opcode, alu_ce, cy_ce} !== 14'h0) begin
            n_err++;
            $display("FAIL mid reset: got %h expected 0", {rom_addr, opcode, alu_ce, cy_ce});
        end
        repeat (2) tick;
        n_vec++;
        if ({opcode, alu_ce} !== 5'b0001_1) begin
            n_err++;
            $display("FAIL mid restart ld: got %b expected 00011", {opcode, alu_ce});
        end
        repeat (7) tick;
        n_vec++;
        if ({rom_addr, halted} !== {8'h02, 1'b1}) begin
            n_err++;
            $display("FAIL mid halted: got %h/%b expected 02/1", rom_addr, halted);
        end
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        n_vec++;
        if ({rom_addr, halted} !== {8'h00, 1'b0}) begin
            n_err++;
            $display("FAIL halt reset: got %h/%b expected 00/0", rom_addr, halted);
        end
        repeat (2) tick;
        n_vec++;
        if ({opcode, alu_ce} !== 5'b0001_1) begin
            n_err++;
            $display("FAIL halt restart ld: got %b expected 00011", {opcode, alu_ce});
        end
    endtask

    task automatic test_undefined;
        clear_rom;
        rom[0] = 12'hB05;
        rom[1] = 12'h101;
        rom[2] = 12'hF00;
        regs[1] = 8'h42;
        regs[5] = 8'h99;
        do_reset;
        en = 1'b1;
        predict(8);
        drain("undefined");
        n_vec++;
        if (acc !== 8'h42) begin
            n_err++;
            $display("FAIL undefined acc: got %h expected 42", acc);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] ops [12];
        logic [3:0] op;
        logic [7:0] opnd;
        ops = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD};
        for (int trial = 0; trial < 3; trial++) begin
            clear_rom;
            for (int i = 0; i < 8; i++) regs[i] = 8'($urandom);
            for (int i = 0; i < 20; i++) begin
                op   = ops[$urandom_range(0, 11)];
                opnd = (op == 4'h9 || op == 4'hA) ? 8'(i + 2) : 8'($urandom);
                rom[i] = {op, opnd};
            end
            rom[20] = 12'hF00;
            rom[21] = 12'hF00;
            do_reset;
            en = 1'b1;
            predict(64);
            drain("back_to_back");
            n_vec++;
            if ({acc, halted} !== {m_acc, 1'b1}) begin
                n_err++;
                $display("FAIL back_to_back acc/halted trial %0d: got %h/%b expected %h/1", trial, acc, halted, m_acc);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        alu_clr = 1'b1;
        m_acc   = 8'h00;
        m_cy    = 1'b0;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        clear_rom;
        test_reset;
        test_basic;
        test_cond_jumps;
        test_wrap;
        test_stall;
        test_reset_mid;
        test_undefined;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
